// File: rtl/mem_stage.sv
// mem_stage: ARM pipeline memory stage with E/M and M/W registers, data-memory handshake,
// stall generation and access timeout. Optional byte lanes enabled by `define MEM_BYTE_EN.
`default_nettype none

module mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWriteE,
    input  logic        MemtoRegE,
    input  logic        MemWriteE,
    input  logic [3:0]  RdE,
    input  logic [31:0] ALUResultE,
    input  logic [31:0] WriteDataE,
`ifdef MEM_BYTE_EN
    input  logic        ByteE,
    output logic [3:0]  DByteEn,
`endif
    output logic [31:0] ALUResultM,
    output logic [3:0]  RdM,
    output logic        RegWriteM,
    output logic        MemStallM,
    output logic        DReq,
    output logic        DWrite,
    output logic [31:0] DAddr,
    output logic [31:0] DWData,
    input  logic [31:0] DRData,
    input  logic        DReady,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic [3:0]  RdW,
    output logic [31:0] ALUOutW,
    output logic [31:0] ReadDataW,
    output logic        MemErr
);

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_BUSY = 1'b1;
    localparam int         c_CW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [0:0]      r_state;
    logic [0:0]      w_next;
    logic [c_CW-1:0] r_waitcnt;
    logic            w_memop;
    logic            w_dreq;
    logic            w_stall;
    logic            w_timeout;
    logic [31:0]     w_rdata;

    logic        r_RegWriteM, r_MemtoRegM, r_MemWriteM;
    logic [3:0]  r_RdM;
    logic [31:0] r_ALUResultM, r_WriteDataM;
    logic        r_RegWriteW, r_MemtoRegW;
    logic [3:0]  r_RdW;
    logic [31:0] r_ALUOutW, r_ReadDataW;
    logic        r_MemErr;
    logic [31:0] w_wdata_e;

    assign w_memop = r_MemtoRegM | r_MemWriteM;

    generate
        if (TIMEOUT > 0) begin : g_timeout
            assign w_timeout = (r_state == c_S_BUSY) && (r_waitcnt == c_CW'(TIMEOUT - 1)) && !DReady;
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_S_IDLE: if (w_memop && !DReady) w_next = c_S_BUSY;
            c_S_BUSY: if (DReady || w_timeout) w_next = c_S_IDLE;
            default:  w_next = c_S_IDLE;
        endcase
    end

    // A timed-out access is released like a completed one so the instruction retires.
    always_comb begin
        w_dreq  = w_memop && ((r_state == c_S_IDLE) || (r_state == c_S_BUSY));
        w_stall = w_dreq && !DReady && !w_timeout;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_waitcnt <= '0;
            r_MemErr  <= 1'b0;
        end else begin
            if (r_state == c_S_IDLE && w_next == c_S_BUSY) begin
                r_waitcnt <= '0;
            end else if (r_state == c_S_BUSY) begin
                r_waitcnt <= r_waitcnt + 1'b1;
            end
            if (w_timeout) begin
                r_MemErr <= 1'b1;
            end
        end
    end

`ifdef MEM_BYTE_EN
    logic        r_ByteM;
    logic [31:0] w_lane;
    assign w_wdata_e = ByteE ? {4{WriteDataE[7:0]}} : WriteDataE;
    assign w_lane    = DRData >> {r_ALUResultM[1:0], 3'b000};
    assign w_rdata   = r_ByteM ? {24'h0, w_lane[7:0]} : DRData;
    assign DByteEn   = r_ByteM ? (4'b0001 << r_ALUResultM[1:0]) : 4'hF;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ByteM <= 1'b0;
        end else if (!w_stall) begin
            r_ByteM <= ByteE;
        end
    end
`else
    assign w_wdata_e = WriteDataE;
    assign w_rdata   = DRData;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_RegWriteM  <= 1'b0;
            r_MemtoRegM  <= 1'b0;
            r_MemWriteM  <= 1'b0;
            r_RdM        <= '0;
            r_ALUResultM <= '0;
            r_WriteDataM <= '0;
        end else if (!w_stall) begin
            r_RegWriteM  <= RegWriteE;
            r_MemtoRegM  <= MemtoRegE;
            r_MemWriteM  <= MemWriteE;
            r_RdM        <= RdE;
            r_ALUResultM <= ALUResultE;
            r_WriteDataM <= w_wdata_e;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_RegWriteW <= 1'b0;
            r_MemtoRegW <= 1'b0;
            r_RdW       <= '0;
            r_ALUOutW   <= '0;
            r_ReadDataW <= '0;
        end else begin
            if (w_stall) begin
                r_RegWriteW <= 1'b0;
                r_MemtoRegW <= 1'b0;
            end else begin
                r_RegWriteW <= r_RegWriteM;
                r_MemtoRegW <= r_MemtoRegM;
                r_RdW       <= r_RdM;
                r_ALUOutW   <= r_ALUResultM;
            end
            r_ReadDataW <= (r_MemtoRegM && DReady) ? w_rdata : 32'h0;
        end
    end

    assign ALUResultM = r_ALUResultM;
    assign RdM        = r_RdM;
    assign RegWriteM  = r_RegWriteM;
    assign MemStallM  = w_stall;
    assign DReq       = w_dreq;
    assign DWrite     = r_MemWriteM;
    assign DAddr      = r_ALUResultM;
    assign DWData     = r_WriteDataM;
    assign RegWriteW  = r_RegWriteW;
    assign MemtoRegW  = r_MemtoRegW;
    assign RdW        = r_RdW;
    assign ALUOutW    = r_ALUOutW;
    assign ReadDataW  = r_ReadDataW;
    assign MemErr     = r_MemErr;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage (TIMEOUT=16).
`default_nettype none

module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteE, MemtoRegE, MemWriteE;
    logic [3:0]  RdE;
    logic [31:0] ALUResultE, WriteDataE;
    logic [31:0] ALUResultM;
    logic [3:0]  RdM;
    logic        RegWriteM, MemStallM, DReq, DWrite;
    logic [31:0] DAddr, DWData, DRData;
    logic        DReady;
    logic        RegWriteW, MemtoRegW;
    logic [3:0]  RdW;
    logic [31:0] ALUOutW, ReadDataW;
    logic        MemErr;
`ifdef MEM_BYTE_EN
    logic        ByteE;
    logic [3:0]  DByteEn;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .RdE(RdE), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
`ifdef MEM_BYTE_EN
        .ByteE(ByteE), .DByteEn(DByteEn),
`endif
        .ALUResultM(ALUResultM), .RdM(RdM), .RegWriteM(RegWriteM),
        .MemStallM(MemStallM), .DReq(DReq), .DWrite(DWrite),
        .DAddr(DAddr), .DWData(DWData), .DRData(DRData), .DReady(DReady),
        .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .RdW(RdW),
        .ALUOutW(ALUOutW), .ReadDataW(ReadDataW), .MemErr(MemErr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_e(input logic rw, input logic m2r, input logic mw,
                           input logic [3:0] rd, input logic [31:0] alu, input logic [31:0] wd);
        RegWriteE  = rw;
        MemtoRegE  = m2r;
        MemWriteE  = mw;
        RdE        = rd;
        ALUResultE = alu;
        WriteDataE = wd;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive_e(0, 0, 0, 4'h0, 32'h0, 32'h0);
        DReady = 1'b1;
        DRData = 32'h0;
`ifdef MEM_BYTE_EN
        ByteE = 1'b0;
`endif
        #12;
        total++;
        if ({DReq, MemStallM, RegWriteW, MemtoRegW, MemErr, RegWriteM} !== 6'b0 ||
            RdW !== 4'h0 || ALUOutW !== 32'h0 || ReadDataW !== 32'h0 || ALUResultM !== 32'h0) begin
            bad++;
            $display("FAIL reset_state: DReq=%b stall=%b RWW=%b M2RW=%b err=%b RdW=%h ALUOutW=%h RDW=%h, required all 0",
                     DReq, MemStallM, RegWriteW, MemtoRegW, MemErr, RdW, ALUOutW, ReadDataW);
        end
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_zero_wait_load();
        drive_e(1, 1, 0, 4'h3, 32'h100, 32'h0);
        DReady = 1'b1;
        DRData = 32'hDEADBEEF;
        step();
        drive_e(0, 0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        total++;
        if (DReq !== 1'b1 || DWrite !== 1'b0 || DAddr !== 32'h100 || MemStallM !== 1'b0 ||
            RdM !== 4'h3 || RegWriteM !== 1'b1) begin
            bad++;
            $display("FAIL ldr_m: DReq=%b DWrite=%b DAddr=%h stall=%b RdM=%h RWM=%b, required 1 0 100 0 3 1",
                     DReq, DWrite, DAddr, MemStallM, RdM, RegWriteM);
        end
        step();
        total++;
        if (ReadDataW !== 32'hDEADBEEF || MemtoRegW !== 1'b1 || RegWriteW !== 1'b1 ||
            RdW !== 4'h3 || ALUOutW !== 32'h100 || DReq !== 1'b0) begin
            bad++;
            $display("FAIL ldr_w: RDW=%h M2RW=%b RWW=%b RdW=%h ALUOutW=%h DReq=%b, required deadbeef 1 1 3 100 0",
                     ReadDataW, MemtoRegW, RegWriteW, RdW, ALUOutW, DReq);
        end
    endtask

    task automatic test_wait_store();
        int writes = 0;
        drive_e(0, 0, 1, 4'h0, 32'h40, 32'h55AA);
        DReady = 1'b0;
        step();
        drive_e(1, 0, 0, 4'h1, 32'h999, 32'h0);
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if (MemStallM !== 1'b1 || DReq !== 1'b1 || DWrite !== 1'b1 || DAddr !== 32'h40 ||
                DWData !== 32'h55AA || RegWriteW !== 1'b0) begin
                bad++;
                $display("FAIL str_wait%0d: stall=%b DReq=%b DWrite=%b DAddr=%h DWData=%h RWW=%b, required 1 1 1 40 55aa 0",
                         k, MemStallM, DReq, DWrite, DAddr, DWData, RegWriteW);
            end
            if (DReq && DWrite && DReady) writes++;
            step();
        end
        DReady = 1'b1;
        #1;
        if (DReq && DWrite && DReady) writes++;
        total++;
        if (MemStallM !== 1'b0 || DAddr !== 32'h40) begin
            bad++;
            $display("FAIL str_done: stall=%b DAddr=%h, required 0 40", MemStallM, DAddr);
        end
        step();
        drive_e(0, 0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        if (DReq && DWrite && DReady) writes++;
        total++;
        if (writes != 1 || RdM !== 4'h1 || RegWriteM !== 1'b1 || RegWriteW !== 1'b0) begin
            bad++;
            $display("FAIL str_single: writes=%0d RdM=%h RWM=%b RWW=%b, required 1 1 1 0",
                     writes, RdM, RegWriteM, RegWriteW);
        end
        step();
    endtask

    task automatic test_back_to_back();
        DReady = 1'b1;
        DRData = 32'hCAFEF00D;
        drive_e(1, 1, 0, 4'h5, 32'h80, 32'h0);
        step();
        drive_e(0, 0, 1, 4'h0, 32'h84, 32'h1234);
        #1;
        total++;
        if (DReq !== 1'b1 || DWrite !== 1'b0 || DAddr !== 32'h80) begin
            bad++;
            $display("FAIL b2b_ldr: DReq=%b DWrite=%b DAddr=%h, required 1 0 80", DReq, DWrite, DAddr);
        end
        step();
        drive_e(0, 0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        total++;
        if (DReq !== 1'b1 || DWrite !== 1'b1 || DAddr !== 32'h84 || DWData !== 32'h1234 ||
            ReadDataW !== 32'hCAFEF00D || MemtoRegW !== 1'b1 || RdW !== 4'h5) begin
            bad++;
            $display("FAIL b2b_str: DReq=%b DWrite=%b DAddr=%h DWData=%h RDW=%h M2RW=%b RdW=%h, required 1 1 84 1234 cafef00d 1 5",
                     DReq, DWrite, DAddr, DWData, ReadDataW, MemtoRegW, RdW);
        end
        step();
        total++;
        if (DReq !== 1'b0 || MemtoRegW !== 1'b0 || RegWriteW !== 1'b0 || ReadDataW !== 32'h0) begin
            bad++;
            $display("FAIL b2b_after: DReq=%b M2RW=%b RWW=%b RDW=%h, required 0 0 0 0",
                     DReq, MemtoRegW, RegWriteW, ReadDataW);
        end
    endtask

    task automatic test_reset_busy();
        DReady = 1'b1;
        drive_e(1, 0, 0, 4'h7, 32'h777, 32'h0);
        step();
        drive_e(1, 1, 0, 4'h8, 32'h200, 32'h0);
        DReady = 1'b0;
        step();
        drive_e(0, 0, 0, 4'h0, 32'h0, 32'h0);
        step();
        total++;
        if (DReq !== 1'b1 || MemStallM !== 1'b1 || RdW !== 4'h7 || ALUOutW !== 32'h777 || RegWriteW !== 1'b0) begin
            bad++;
            $display("FAIL busy_pre: DReq=%b stall=%b RdW=%h ALUOutW=%h RWW=%b, required 1 1 7 777 0",
                     DReq, MemStallM, RdW, ALUOutW, RegWriteW);
        end
        #1 reset = 1'b0;
        #1;
        total++;
        if (DReq !== 1'b0 || MemStallM !== 1'b0 || RdW !== 4'h0 || ALUOutW !== 32'h0 ||
            RegWriteW !== 1'b0 || MemtoRegW !== 1'b0 || ReadDataW !== 32'h0 || RegWriteM !== 1'b0) begin
            bad++;
            $display("FAIL busy_reset: DReq=%b stall=%b RdW=%h ALUOutW=%h RWW=%b M2RW=%b RDW=%h RWM=%b, required all 0",
                     DReq, MemStallM, RdW, ALUOutW, RegWriteW, MemtoRegW, ReadDataW, RegWriteM);
        end
        #3 reset = 1'b1;
        DReady = 1'b1;
        DRData = 32'h0BADF00D;
        step();
        drive_e(1, 1, 0, 4'h2, 32'h10, 32'h0);
        step();
        drive_e(0, 0, 0, 4'h0, 32'h0, 32'h0);
        step();
        total++;
        if (ReadDataW !== 32'h0BADF00D || RdW !== 4'h2 || MemtoRegW !== 1'b1) begin
            bad++;
            $display("FAIL busy_release: RDW=%h RdW=%h M2RW=%b, required 0badf00d 2 1", ReadDataW, RdW, MemtoRegW);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        DReady = 1'b0;
        DRData = 32'h12345678;
        drive_e(1, 1, 0, 4'h9, 32'h300, 32'h0);
        step();
        drive_e(0, 0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        while (MemStallM === 1'b1 && n < 40) begin
            n++;
            step();
        end
        total++;
        if (n != 16 || MemErr !== 1'b0 || DReq !== 1'b1) begin
            bad++;
            $display("FAIL to_stall: stall_cycles=%0d err=%b DReq=%b, required 16 0 1", n, MemErr, DReq);
        end
        step();
        total++;
        if (MemErr !== 1'b1 || ReadDataW !== 32'h0 || MemtoRegW !== 1'b1 || RdW !== 4'h9 ||
            MemStallM !== 1'b0 || DReq !== 1'b0) begin
            bad++;
            $display("FAIL to_done: err=%b RDW=%h M2RW=%b RdW=%h stall=%b DReq=%b, required 1 0 1 9 0 0",
                     MemErr, ReadDataW, MemtoRegW, RdW, MemStallM, DReq);
        end
        DReady = 1'b1;
        drive_e(1, 1, 0, 4'h4, 32'h20, 32'h0);
        step();
        drive_e(0, 0, 0, 4'h0, 32'h0, 32'h0);
        step();
        total++;
        if (MemErr !== 1'b1 || ReadDataW !== 32'h12345678) begin
            bad++;
            $display("FAIL to_sticky: err=%b RDW=%h, required 1 12345678", MemErr, ReadDataW);
        end
        #1 reset = 1'b0;
        #1;
        total++;
        if (MemErr !== 1'b0) begin
            bad++;
            $display("FAIL to_clear: err=%b, required 0", MemErr);
        end
        #3 reset = 1'b1;
        step();
    endtask

`ifdef MEM_BYTE_EN
    task automatic test_byte();
        DReady = 1'b1;
        DRData = 32'h11223344;
        ByteE  = 1'b1;
        drive_e(0, 0, 1, 4'h0, 32'h203, 32'h000000AB);
        step();
        drive_e(1, 1, 0, 4'h6, 32'h201, 32'h0);
        #1;
        total++;
        if (DByteEn !== 4'b1000 || DWData !== 32'hABABABAB || DWrite !== 1'b1) begin
            bad++;
            $display("FAIL strb: DByteEn=%b DWData=%h DWrite=%b, required 1000 abababab 1", DByteEn, DWData, DWrite);
        end
        step();
        ByteE = 1'b0;
        drive_e(0, 0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        total++;
        if (DByteEn !== 4'b0010) begin
            bad++;
            $display("FAIL ldrb_en: DByteEn=%b, required 0010", DByteEn);
        end
        step();
        total++;
        if (ReadDataW !== 32'h33 || DByteEn !== 4'hF) begin
            bad++;
            $display("FAIL ldrb: RDW=%h DByteEn=%b, required 33 1111", ReadDataW, DByteEn);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_zero_wait_load();
        test_wait_store();
        test_back_to_back();
        test_reset_busy();
        test_timeout();
`ifdef MEM_BYTE_EN
        test_byte();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
